// File: rtl/multicycle_alu_if.sv
`timescale 1ns/1ps
// multicycle_alu_if: start/busy/done handshake, operands and result/flag bus of the multicycle ALU.
interface multicycle_alu_if #(parameter int WIDTH = 16);
    logic             start;
    logic [3:0]       Function;
    logic [WIDTH-1:0] operandA, operandB;
    logic             busy, done;
    logic [WIDTH-1:0] res, res_hi;
    logic             zero, carry, overflow, negative, takeBranch, illegal;
    modport master(output start, Function, operandA, operandB,
                   input busy, done, res, res_hi, zero, carry, overflow, negative, takeBranch, illegal);
    modport slave(input start, Function, operandA, operandB,
                  output busy, done, res, res_hi, zero, carry, overflow, negative, takeBranch, illegal);
endinterface

// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
// multicycle_alu: sequential ALU with iterative shifts, shift-add multiplier and start/busy/done handshake.
// Branch compares (EQ/NE) report only takeBranch; their res is 0.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst_n,
    multicycle_alu_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2, DONE = 2'd3;
    localparam logic [3:0] F_AND = 4'h0, F_ADD = 4'h1, F_SUB = 4'h2, F_SLL = 4'h3, F_SRL = 4'h4,
                           F_SRA = 4'h5, F_MUL = 4'h6, F_EQ = 4'h7, F_NE = 4'h8, F_PASSA = 4'h9,
                           F_PASSB = 4'hA, F_OR = 4'hB, F_XOR = 4'hC;
    logic [1:0]         st;
    logic [3:0]         fn, op;
    logic [WIDTH-1:0]   a_r, sh1, x, y, r, rh;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH:0]     sum, dif, mac;
    logic [SHW:0]       cnt;
    logic               c, v, t, il, is_sh, last, upd;
    assign bus.busy = st == SHIFT || st == MUL;
    assign bus.done = st == DONE;
    assign is_sh = bus.Function inside {F_SLL, F_SRL, F_SRA};
    assign last = cnt == (SHW+1)'(1);
    // In IDLE the result is formed straight from the inputs; later from the latched working registers.
    always_comb begin
        op = st == IDLE ? bus.Function : fn;
        x = st == IDLE ? bus.operandA : a_r;
        y = bus.operandB;
        sh1 = fn == F_SLL ? {a_r[WIDTH-2:0], 1'b0} : fn == F_SRL ? {1'b0, a_r[WIDTH-1:1]} : {a_r[WIDTH-1], a_r[WIDTH-1:1]};
        mac = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
        acc_nx = {mac, acc[WIDTH-1:1]};
        sum = {1'b0, x} + {1'b0, y};
        dif = {1'b0, x} - {1'b0, y};
        r = '0;
        rh = '0;
        c = 1'b0;
        v = 1'b0;
        t = 1'b0;
        il = 1'b0;
        case (op)
            F_AND: r = x & y;
            F_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = x[WIDTH-1] == y[WIDTH-1] && sum[WIDTH-1] != x[WIDTH-1];
            end
            F_SUB: begin
                r = dif[WIDTH-1:0];
                c = dif[WIDTH];
                v = x[WIDTH-1] != y[WIDTH-1] && dif[WIDTH-1] != x[WIDTH-1];
            end
            F_SLL, F_SRL, F_SRA: r = st == SHIFT ? sh1 : x;
            F_MUL: {rh, r} = acc_nx;
            F_EQ: t = x == y;
            F_NE: t = x != y;
            F_PASSA: r = x;
            F_PASSB: r = y;
            F_OR: r = x | y;
            F_XOR: r = x ^ y;
            default: il = 1'b1;
        endcase
        upd = st == IDLE ? bus.start && bus.Function != F_MUL && !(is_sh && |bus.operandB[SHW-1:0])
                         : (st == SHIFT || st == MUL) && last;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            fn <= '0;
            a_r <= '0;
            acc <= '0;
            cnt <= '0;
            bus.res <= '0;
            bus.res_hi <= '0;
            bus.zero <= 1'b0;
            bus.carry <= 1'b0;
            bus.overflow <= 1'b0;
            bus.negative <= 1'b0;
            bus.takeBranch <= 1'b0;
            bus.illegal <= 1'b0;
        end else begin
            if (upd) begin
                bus.res <= r;
                bus.res_hi <= rh;
                bus.zero <= r == '0 && rh == '0;
                bus.carry <= c;
                bus.overflow <= v;
                bus.negative <= op == F_MUL ? rh[WIDTH-1] : r[WIDTH-1];
                bus.takeBranch <= t;
                bus.illegal <= il;
            end
            case (st)
                IDLE: if (bus.start) begin
                    fn <= bus.Function;
                    a_r <= bus.operandA;
                    acc <= {{WIDTH{1'b0}}, bus.operandB};
                    cnt <= bus.Function == F_MUL ? (SHW+1)'(WIDTH) : {1'b0, bus.operandB[SHW-1:0]};
                    st <= bus.Function == F_MUL ? MUL : is_sh && |bus.operandB[SHW-1:0] ? SHIFT : DONE;
                end
                SHIFT: begin
                    a_r <= sh1;
                    cnt <= cnt - 1'b1;
                    if (last) st <= DONE;
                end
                MUL: begin
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (last) st <= DONE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
// tb_multicycle_alu: table vectors, directed handshake/reset sequences and randomized ops
// checked against an arithmetic reference model.
module tb_multicycle_alu;
    typedef struct packed {
        logic [15:0] res, hi;
        logic        z, c, v, n, t, il;
        logic [7:0]  lat;
    } out_t;
    typedef struct {
        logic [3:0]  f;
        logic [15:0] a, b;
        out_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[16];

    multicycle_alu_if #(.WIDTH(16)) bus();
    multicycle_alu #(.WIDTH(16)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic out_t mk(input logic [15:0] res, hi, input logic z, c, v, n, t, il, input int lat);
        mk = '{res: res, hi: hi, z: z, c: c, v: v, n: n, t: t, il: il, lat: 8'(lat)};
    endfunction

    // Reference: plain integer arithmetic on the whole operands, latency from the op's rule.
    function automatic out_t model(input logic [3:0] f, input logic [15:0] a, b);
        out_t        e;
        int          k, s;
        logic [16:0] w;
        logic [31:0] p;
        e = '0;
        e.lat = 8'd1;
        k = int'(b[3:0]);
        case (f)
            4'h0: e.res = a & b;
            4'h1: begin
                w = {1'b0, a} + {1'b0, b};
                e.res = w[15:0];
                e.c = w[16];
                s = int'($signed(a)) + int'($signed(b));
                e.v = s > 32767 || s < -32768;
            end
            4'h2: begin
                e.res = a - b;
                e.c = a < b;
                s = int'($signed(a)) - int'($signed(b));
                e.v = s > 32767 || s < -32768;
            end
            4'h3: begin e.res = a << k; e.lat = 8'(1 + k); end
            4'h4: begin e.res = a >> k; e.lat = 8'(1 + k); end
            4'h5: begin e.res = $signed(a) >>> k; e.lat = 8'(1 + k); end
            4'h6: begin
                p = 32'(a) * 32'(b);
                e.hi = p[31:16];
                e.res = p[15:0];
                e.lat = 8'd17;
            end
            4'h7: e.t = a == b;
            4'h8: e.t = a != b;
            4'h9: e.res = a;
            4'hA: e.res = b;
            4'hB: e.res = a | b;
            4'hC: e.res = a ^ b;
            default: e.il = 1'b1;
        endcase
        e.z = {e.hi, e.res} == 32'd0;
        e.n = f == 4'h6 ? e.hi[15] : e.res[15];
        return e;
    endfunction

    function automatic out_t obs(input int lat);
        obs = '{res: bus.res, hi: bus.res_hi, z: bus.zero, c: bus.carry, v: bus.overflow,
                n: bus.negative, t: bus.takeBranch, il: bus.illegal, lat: 8'(lat)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one op; inputs are scrambled while it is in flight. lat=0 means done never arrived.
    task automatic run(input logic [3:0] f, input logic [15:0] a, b, output out_t o, output bit bok);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Function = f;
        bus.operandA = a;
        bus.operandB = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        bok = 1'b1;
        while (!bus.done && cyc < 40) begin
            if (!bus.busy) bok = 1'b0;
            bus.operandA = 16'($urandom);
            bus.operandB = 16'($urandom);
            bus.Function = 4'($urandom);
            @(negedge clk);
            cyc++;
        end
        if (bus.busy) bok = 1'b0;
        o = obs(bus.done ? cyc : 0);
    endtask

    initial begin
        out_t  o, e;
        bit    bok;
        int    cnt, cyc;
        logic [3:0]  f;
        logic [15:0] a, b;
        bus.start = 1'b0;
        bus.Function = 4'h0;
        bus.operandA = 16'h0;
        bus.operandB = 16'h0;
        repeat (3) @(negedge clk);
        check("reset", 64'({bus.busy, bus.done, obs(0)}), 64'd0);
        rst_n = 1'b1;

        tbl[0]  = '{4'h1, 16'h7FFF, 16'h0001, mk(16'h8000, 16'h0000, 0, 0, 1, 1, 0, 0, 1)};
        tbl[1]  = '{4'h2, 16'h0003, 16'h0005, mk(16'hFFFE, 16'h0000, 0, 1, 0, 1, 0, 0, 1)};
        tbl[2]  = '{4'h3, 16'h0001, 16'h0013, mk(16'h0008, 16'h0000, 0, 0, 0, 0, 0, 0, 4)};
        tbl[3]  = '{4'h5, 16'h8000, 16'h0004, mk(16'hF800, 16'h0000, 0, 0, 0, 1, 0, 0, 5)};
        tbl[4]  = '{4'h4, 16'hABCD, 16'h0010, mk(16'hABCD, 16'h0000, 0, 0, 0, 1, 0, 0, 1)};
        tbl[5]  = '{4'h6, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 0, 0, 0, 1, 0, 0, 17)};
        tbl[6]  = '{4'h6, 16'h1234, 16'h0000, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 17)};
        tbl[7]  = '{4'h7, 16'h00A5, 16'h00A5, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0, 1)};
        tbl[8]  = '{4'h8, 16'h00A5, 16'h00A5, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1)};
        tbl[9]  = '{4'hE, 16'h1234, 16'h5678, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, 1, 1)};
        tbl[10] = '{4'h0, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 16'h0000, 0, 0, 0, 0, 0, 0, 1)};
        tbl[11] = '{4'hC, 16'hFFFF, 16'h0001, mk(16'hFFFE, 16'h0000, 0, 0, 0, 1, 0, 0, 1)};
        tbl[12] = '{4'hA, 16'h1234, 16'h0000, mk(16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 1)};
        tbl[13] = '{4'h2, 16'h8000, 16'h0001, mk(16'h7FFF, 16'h0000, 0, 0, 1, 0, 0, 0, 1)};
        tbl[14] = '{4'h1, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 1)};
        tbl[15] = '{4'h6, 16'h00FF, 16'h0100, mk(16'hFF00, 16'h0000, 0, 0, 0, 0, 0, 0, 17)};
        for (int i = 0; i < 16; i++) begin
            run(tbl[i].f, tbl[i].a, tbl[i].b, o, bok);
            check($sformatf("vec%0d", i), 64'(o), 64'(tbl[i].e));
            check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
        end

        for (int i = 0; i < 150; i++) begin
            f = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = i % 2 == 0 ? 16'($urandom) : 16'($urandom_range(0, 3));
            run(f, a, b, o, bok);
            check($sformatf("rnd%0d_f%h", i, f), 64'(o), 64'(model(f, a, b)));
            if (i % 10 == 0) check($sformatf("rnd%0d_busy", i), 64'(bok), 64'd1);
        end

        // start held high with ADD: one done every second cycle, never busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.Function = 4'h1;
        bus.operandA = 16'h1111;
        bus.operandB = 16'h2222;
        cnt = 0;
        bok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) cnt++;
            if (bus.busy) bok = 1'b0;
        end
        bus.start = 1'b0;
        check("b2b_dones", 64'(cnt), 64'd10);
        check("b2b_busy", 64'(bok), 64'd1);
        @(negedge clk);
        e = model(4'h1, 16'h1111, 16'h2222);
        e.lat = 8'd0;
        check("b2b_res", 64'(obs(0)), 64'(e));

        // start pulsed mid-MUL is ignored; results then hold while inputs wander.
        @(negedge clk);
        bus.start = 1'b1;
        bus.Function = 4'h6;
        bus.operandA = 16'hFFFF;
        bus.operandB = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            bus.start = cyc == 5;
            bus.Function = 4'h1;
            bus.operandA = 16'h0001;
            bus.operandB = 16'h0001;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("mul_pulse", 64'(obs(bus.done ? cyc : 0)), 64'(mk(16'h0001, 16'hFFFE, 0, 0, 0, 1, 0, 0, 17)));
        cnt = 0;
        repeat (5) begin
            bus.operandA = 16'($urandom);
            bus.operandB = 16'($urandom);
            bus.Function = 4'($urandom);
            @(negedge clk);
            if (bus.done || bus.busy) cnt++;
        end
        check("hold_idle", 64'(cnt), 64'd0);
        check("hold_res", 64'(obs(0)), 64'(mk(16'h0001, 16'hFFFE, 0, 0, 0, 1, 0, 0, 0)));

        // Reset in the fifth cycle of a MUL clears everything and suppresses done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.Function = 4'h6;
        bus.operandA = 16'h00FF;
        bus.operandB = 16'h0100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mul", 64'({bus.busy, bus.done, obs(0)}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) cnt++;
        end
        check("rst_no_done", 64'(cnt), 64'd0);
        run(4'h1, 16'h7FFF, 16'h0001, o, bok);
        check("post_rst_add", 64'(o), 64'(model(4'h1, 16'h7FFF, 16'h0001)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, sequential successor to the processor's combinational ALU.
- Adds iterative shifts and an iterative shift-add multiplier, full status flags, and a start/busy/done handshake.
- Every function code is unique; illegal codes are flagged.
- Sits in the EX stage of the multicycle datapath; the control FSM issues `start` and waits for `done` before write-back or branch resolution.

Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount field width taken from operandB[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled in IDLE only.
- Function  input  4  operation code, latched on accepted start.
- operandA  input  WIDTH  first operand, latched on accepted start.
- operandB  input  WIDTH  second operand / shift amount, latched on accepted start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- res  output  WIDTH  result (low half for MUL).
- res_hi  output  WIDTH  high half of MUL product; 0 for all other ops.
- zero  output  1  result == 0 (full 2*WIDTH product for MUL).
- carry  output  1  ADD: carry-out. SUB: borrow (A<B unsigned). Otherwise 0.
- overflow  output  1  signed overflow for ADD/SUB. Otherwise 0.
- negative  output  1  res[WIDTH-1] (res_hi MSB for MUL).
- takeBranch  output  1  EQ: A==B. NE: A!=B. Otherwise 0.
- illegal  output  1  Function was an unassigned code.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, all flags, res, res_hi, illegal = 0. Reset mid-operation aborts it; no done is produced.
- Function codes:
  - 0000 AND, 0001 ADD, 0010 SUB, 0011 SLL, 0100 SRL.
  - 0101 SRA (arithmetic right shift).
  - 0110 MUL (unsigned, 2*WIDTH product).
  - 0111 EQ, 1000 NE.
  - 1001 PASSA (res=A), 1010 PASSB (res=B).
  - 1011 OR, 1100 XOR.
  - 1101–1111 illegal: res=0, illegal=1, zero=1, all other flags 0.
- States:
  - IDLE: start=1 latches Function and operands. Single-cycle ops and illegal codes → DONE. Shifts with k=B[SHW-1:0]: k=0 → DONE, else → SHIFT. MUL → MUL.
  - SHIFT: one bit position per cycle, k cycles, then → DONE.
  - MUL: one multiplier bit per cycle (LSB first, add-then-shift on a 2*WIDTH accumulator), exactly WIDTH cycles, then → DONE.
  - DONE: done=1 for exactly one cycle, busy=0, → IDLE.
- Latency: start accepted at edge N. done is asserted in cycle:
  - N+1 for single-cycle ops, illegal codes and k=0 shifts.
  - N+1+k for shifts.
  - N+1+WIDTH for MUL.
  - busy is high between acceptance and done; busy and done are never high together.
- Outputs and flags update only in the done cycle, then hold until the next accepted start.
- start while busy or in DONE: ignored (not queued). start in the IDLE cycle right after DONE is accepted, giving back-to-back throughput.
- Shift amount uses only B[SHW-1:0]; upper bits of B are ignored.
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits; carry is bit WIDTH.
  - overflow = operand signs equal (ADD) or different (SUB) and result sign differs from A.
  - All results wrap modulo 2^WIDTH.
- Inputs changing while busy do not affect the in-flight operation.

Test Plan:
- Reset mid-MUL: MUL 0x00FF*0x0100, assert rst_n=0 at cycle 5 → all outputs 0 immediately; no done pulse after release.
- ADD/SUB: ADD 0x7FFF+0x0001 → res=0x8000, overflow=1, negative=1, carry=0, done at N+1. SUB 0x0003-0x0005 → res=0xFFFE, carry=1, overflow=0.
- Shifts: SLL 0x0001 by B=0x0013 (k=3) → res=0x0008, done at N+4. SRA 0x8000 by 4 → 0xF800. SRL by 0 → done at N+1, res=A.
- MUL: 0xFFFF*0xFFFF → res=0x0001, res_hi=0xFFFE, done at N+17; 0x1234*0 → zero=1.
- Branch and illegal: EQ 0x00A5,0x00A5 → takeBranch=1. NE same operands → 0. Function=1110 → illegal=1, res=0, zero=1.
- Handshake: start held high continuously with ADD ops → one done every 2 cycles. start pulsed during MUL busy → ignored; results hold after done until next acceptance.
